// File: rtl/fp_pkg.sv
// fp_pkg: shared constants, FSM encoding and result payload for the FP normalise/round stage.
// Bit layout of the raw mantissa (IN_W wide):
//   [CARRY_POS] carry, [HID_POS:LSB_POS] 24b significand, [G_POS] guard, [R_POS] round, [S_TOP:0] sticky.
package fp_pkg;

    localparam int unsigned IN_W     = 28;
    localparam int unsigned EXP_W    = 10;
    localparam int unsigned MANT_W   = 24;
    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned EXP_MAX  = 255;

    localparam int unsigned CARRY_POS = IN_W - 1;
    localparam int unsigned HID_POS   = IN_W - 2;
    localparam int unsigned LSB_POS   = IN_W - 25;
    localparam int unsigned G_POS     = IN_W - 26;
    localparam int unsigned R_POS     = IN_W - 27;
    localparam int unsigned S_TOP     = IN_W - 28;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Result presented to the packer.
    typedef struct packed {
        logic [MANT_W-1:0] zn;
        logic [7:0]        zen;
        logic              zs;
        logic              ovf;
        logic              unf;
    } fp_res_t;

endpackage

// File: rtl/fp_round.sv
// fp_round: combinational 24b significand incrementer with guard/round/sticky decision.
// Build option: FP_ROUND_EN defined -> round-to-nearest-even; undefined -> truncate.
// Ports:
//   sig        in   24  significand incl. hidden bit
//   g, r, s    in   1   guard, round, sticky bits
//   rounded_c  out  24  significand after optional increment (low 24 bits)
//   carry_c    out  1   increment carried out of 24 bits
module fp_round
    import fp_pkg::*;
(
    input  logic [MANT_W-1:0] sig,
    input  logic              g,
    input  logic              r,
    input  logic              s,
    output logic [MANT_W-1:0] rounded_c,
    output logic              carry_c
);

    logic round_up;

`ifdef FP_ROUND_EN
    // Round half to even: increment above half, or at exactly half when LSB is odd.
    assign round_up = g & (r | s | sig[0]);
`else
    logic unused_grs;
    assign unused_grs = g ^ r ^ s;
    assign round_up   = 1'b0;
`endif

    assign {carry_c, rounded_c} = {1'b0, sig} + {{MANT_W{1'b0}}, round_up};

endmodule

// File: rtl/fp_normalize.sv
// fp_normalize: iterative normalise/round stage ahead of the IEEE-754 single packer.
// Build option: FP_ROUND_EN (round-to-nearest-even when defined, truncate otherwise).
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    raw operand handshake (ready only in IDLE)
//   in_mant/exp/sign     raw mantissa, signed biased exponent, sign
//   out_valid/out_ready  result handshake
//   ZN, ZEN, ZS          normalised significand, biased exponent, sign
//   ovf, unf             overflow-to-inf / flush-to-zero flags
module fp_normalize
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_mant,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_sign,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] ZN,
    output logic [7:0]        ZEN,
    output logic              ZS,
    output logic              ovf,
    output logic              unf
);

    localparam logic signed [EXP_W-1:0] E_ZERO = '0;
    localparam logic signed [EXP_W-1:0] E_ONE  = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] E_MAX  = EXP_W'(EXP_MAX);

    state_t                  state, state_nxt;
    logic [IN_W-1:0]         m_r, m_nxt;
    logic signed [EXP_W-1:0] e_r, e_nxt;
    logic                    s_r, s_nxt;
    fp_res_t                 res, res_nxt;
    logic                    out_valid_nxt, in_ready_nxt;

    logic [MANT_W-1:0]       rnd_sig;
    logic                    rnd_carry;
    logic signed [EXP_W-1:0] e_rnd;
    logic [MANT_W-1:0]       sig_final;

    fp_round u_round (
        .sig       (m_r[HID_POS:LSB_POS]),
        .g         (m_r[G_POS]),
        .r         (m_r[R_POS]),
        .s         (|m_r[S_TOP:0]),
        .rounded_c (rnd_sig),
        .carry_c   (rnd_carry)
    );

    // Rounding overflow wraps the significand to 1.0 and bumps the exponent.
    assign e_rnd     = e_r + (rnd_carry ? E_ONE : E_ZERO);
    assign sig_final = rnd_carry ? MANT_W'(24'h800000) : rnd_sig;

    // State, working operand and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            m_r       <= '0;
            e_r       <= '0;
            s_r       <= 1'b0;
            res       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_nxt;
            m_r       <= m_nxt;
            e_r       <= e_nxt;
            s_r       <= s_nxt;
            res       <= res_nxt;
            out_valid <= out_valid_nxt;
            in_ready  <= in_ready_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        m_nxt     = m_r;
        e_nxt     = e_r;
        s_nxt     = s_r;
        res_nxt   = res;

        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    m_nxt     = in_mant;
                    e_nxt     = in_exp;
                    s_nxt     = in_sign;
                    state_nxt = ST_ALIGN;
                end
            end

            ST_ALIGN: begin
                if (m_r == '0) begin
                    res_nxt   = '{zn: '0, zen: '0, zs: s_r, ovf: 1'b0, unf: 1'b0};
                    state_nxt = ST_DONE;
                end else if (m_r[CARRY_POS]) begin
                    // Right shift folds the dropped bit into sticky.
                    m_nxt     = {1'b0, m_r[IN_W-1:2], m_r[1] | m_r[0]};
                    e_nxt     = e_r + E_ONE;
                    state_nxt = ST_ROUND;
                end else if (!m_r[HID_POS] && (e_r > E_ONE)) begin
                    m_nxt = {m_r[IN_W-2:0], 1'b0};
                    e_nxt = e_r - E_ONE;
                end else if (!m_r[HID_POS]) begin
                    // No subnormals: exponent exhausted before the hidden bit arrived.
                    res_nxt   = '{zn: '0, zen: '0, zs: s_r, ovf: 1'b0, unf: 1'b1};
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_ROUND;
                end
            end

            ST_ROUND: begin
                if (e_rnd >= E_MAX) begin
                    res_nxt = '{zn: '0, zen: 8'hFF, zs: s_r, ovf: 1'b1, unf: 1'b0};
                end else if (e_rnd <= E_ZERO) begin
                    res_nxt = '{zn: '0, zen: '0, zs: s_r, ovf: 1'b0, unf: 1'b1};
                end else begin
                    res_nxt = '{zn: sig_final, zen: e_rnd[7:0], zs: s_r, ovf: 1'b0, unf: 1'b0};
                end
                state_nxt = ST_DONE;
            end

            ST_DONE: begin
                if (out_ready) begin
                    res_nxt.ovf = 1'b0;
                    res_nxt.unf = 1'b0;
                    state_nxt   = ST_IDLE;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase

        out_valid_nxt = (state_nxt == ST_DONE);
        in_ready_nxt  = (state_nxt == ST_IDLE);
    end

    assign ZN  = res.zn;
    assign ZEN = res.zen;
    assign ZS  = res.zs;
    assign ovf = res.ovf;
    assign unf = res.unf;

endmodule

// File: tb/tb_fp_normalize.sv
// tb_fp_normalize: directed and randomized checks of fp_normalize against an arithmetic reference model.
module tb_fp_normalize;
    import fp_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [IN_W-1:0]   in_mant = '0;
    logic [EXP_W-1:0]  in_exp = '0;
    logic              in_sign = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [MANT_W-1:0] ZN;
    logic [7:0]        ZEN;
    logic              ZS;
    logic              ovf;
    logic              unf;

    int checks = 0;
    int errors = 0;

    fp_normalize dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_exp    (in_exp),
        .in_sign   (in_sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ZN        (ZN),
        .ZEN       (ZEN),
        .ZS        (ZS),
        .ovf       (ovf),
        .unf       (unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: value semantics of normalise + round, latency from the number of shifts.
    task automatic model(input logic [27:0] m, input int e, input logic s,
                         output logic [23:0] zn, output int zen, output logic zs,
                         output logic ov, output logic un, output int lat);
        longint mm;
        int     ee, p, k, avail;
        longint sig;
        logic   g, r, st, up;
        zs = s; ov = 0; un = 0; zn = '0; zen = 0;
        mm = longint'(m); ee = e;
        if (m == 0) begin
            lat = 2;
            return;
        end
        if (m[27]) begin
            mm = (mm >> 1) | (mm & 1);
            ee = e + 1;
            lat = 3;
        end else begin
            p = 0;
            for (int i = 0; i < 27; i++) if (m[i]) p = i;
            k = 26 - p;
            avail = (e > 1) ? e - 1 : 0;
            if (k > avail) begin
                un = 1; lat = 2 + avail;
                return;
            end
            mm = mm << k;
            ee = e - k;
            lat = 3 + k;
        end
        sig = (mm >> 3) & 64'hFFFFFF;
        g  = mm[2];
        r  = mm[1];
        st = mm[0];
`ifdef FP_ROUND_EN
        up = g & (r | st | sig[0]);
`else
        up = 1'b0;
        if (g | r | st) up = 1'b0;
`endif
        sig = sig + longint'(up);
        if (sig == 64'h1000000) begin
            sig = 64'h800000;
            ee = ee + 1;
        end
        if (ee >= 255) begin
            ov = 1; zen = 255;
        end else if (ee <= 0) begin
            un = 1;
        end else begin
            zn = sig[23:0]; zen = ee;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Submit one operand, check result/latency, optionally stall, then drain.
    task automatic run_op(input string tag, input logic [27:0] m, input int e, input logic s,
                          input int stall);
        logic [23:0] x_zn; int x_zen; logic x_zs, x_ov, x_un; int x_lat;
        int w, n;
        logic [23:0] h_zn; logic [7:0] h_zen;
        model(m, e, s, x_zn, x_zen, x_zs, x_ov, x_un, x_lat);
        w = 0;
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        in_mant = m; in_exp = EXP_W'(e); in_sign = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 60);
        if (!out_valid) begin
            check({tag, "_timeout"}, 32'(out_valid), 32'd1);
            do_reset();
            return;
        end
        check({tag, "_lat"}, 32'(n), 32'(x_lat));
        check({tag, "_zn"}, 32'(ZN), 32'(x_zn));
        check({tag, "_zen"}, 32'(ZEN), 32'(x_zen));
        check({tag, "_zs"}, 32'(ZS), 32'(x_zs));
        check({tag, "_ovf"}, 32'(ovf), 32'(x_ov));
        check({tag, "_unf"}, 32'(unf), 32'(x_un));
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        h_zn = ZN; h_zen = ZEN;
        for (int i = 0; i < stall; i++) begin
            in_mant = IN_W'($urandom); in_exp = EXP_W'(100); in_valid = 1'b1;
            @(negedge clk);
            check({tag, "_hold_v"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_zn"}, 32'(ZN), 32'(h_zn));
            check({tag, "_hold_zen"}, 32'(ZEN), 32'(h_zen));
            check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_drain_v"}, 32'(out_valid), 32'd0);
        check({tag, "_drain_flags"}, 32'({ovf, unf}), 32'd0);
        check({tag, "_drain_rdy"}, 32'(in_ready), 32'd1);
        if (stall > 0) begin
            // The operand offered while stalled must not have been taken.
            repeat (4) @(negedge clk);
            check({tag, "_no_extra"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        logic [27:0] rm;
        int re, lead;
        repeat (3) @(negedge clk);
        check("rst_outs", 32'({out_valid, ZN, ZEN[6:0]}), 32'd0);
        check("rst_flags", 32'({ZEN[7], ZS, ovf, unf}), 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("unit",   28'h4000000, 127, 1'b0, 0);
        run_op("carry",  28'h8000000, 127, 1'b0, 0);
        run_op("shift4", 28'h0400000, 130, 1'b1, 0);
        run_op("rne",    28'h7FFFFFC, 100, 1'b0, 0);
        run_op("uflow",  28'h0000010, 3,   1'b0, 0);
        run_op("oflow",  28'h8000000, 254, 1'b1, 0);
        run_op("zero",   28'h0000000, 50,  1'b1, 0);
        run_op("tie_ev", 28'h4000004, 127, 1'b0, 0);
        run_op("tie_od", 28'h400000C, 127, 1'b0, 0);
        run_op("stall",  28'h5A5A5A4, 140, 1'b1, 5);

        // Abort during ALIGN: a long-shift operand after a nonzero result.
        run_op("pre_rst", 28'h6000000, 200, 1'b1, 0);
        in_mant = 28'h0000100; in_exp = EXP_W'(200); in_sign = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_v", 32'(out_valid), 32'd0);
        check("abort_rdy", 32'(in_ready), 32'd1);
        check("abort_outs", 32'({ZN, ZEN}), 32'd0);
        check("abort_flags", 32'({ZS, ovf, unf}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_idle", 32'(out_valid), 32'd0);

        for (int t = 0; t < 200; t++) begin
            lead = int'($urandom_range(0, 28));
            rm = IN_W'($urandom);
            if (lead == 28) rm = '0;
            else begin
                rm = rm & ((28'd1 << lead) - 28'd1);
                rm = rm | (28'd1 << lead);
            end
            re = int'($urandom_range(0, 310)) - 5;
            run_op("rand", rm, re, 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
